instr_fetch: RTL and testbench

//   Instruction fetch stage that sits directly upstream of instr_memory. Holds the PC,

---
 rtl/instr_fetch_if.sv | 24 ++
 rtl/instr_fetch.sv | 98 +++++++++
 tb/tb_instr_fetch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory address/data, redirect request from
// execute, and the IF/ID output slot with its valid/ready handshake plus fault report.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    input  imem_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, fault, fault_pc,
    output imem_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, addresses instr_memory combinationally and registers
// the returned word into a one-deep IF/ID slot; traps misaligned/out-of-range PCs.
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);
  localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES) - 32'd4;

  typedef enum logic {RUN, FAULT} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_p0, pc_p0_nxt;
  logic        vld_p1, vld_p1_nxt;
  logic [31:0] instr_p1, instr_p1_nxt;
  logic [31:0] pc_p1, pc_p1_nxt;
  logic        fault_p1, fault_p1_nxt;
  logic [31:0] fault_pc_p1, fault_pc_p1_nxt;
  logic        free;
  logic        bad;

  function automatic logic pc_bad(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p > LAST_PC);
  endfunction

  assign free = !vld_p1 || bus.out_ready;
  assign bad  = pc_bad(pc_p0);

  always_comb begin
    state_nxt       = state;
    pc_p0_nxt       = pc_p0;
    vld_p1_nxt      = vld_p1;
    instr_p1_nxt    = instr_p1;
    pc_p1_nxt       = pc_p1;
    fault_p1_nxt    = fault_p1;
    fault_pc_p1_nxt = fault_pc_p1;
    if (bus.redirect_valid) begin
      // Redirect wins everywhere and discards the pending slot even if decode is taking it.
      pc_p0_nxt    = bus.redirect_pc;
      vld_p1_nxt   = 1'b0;
      fault_p1_nxt = 1'b0;
      state_nxt    = RUN;
    end else begin
      case (state)
        RUN: begin
          if (free) begin
            if (bad) begin
              state_nxt       = FAULT;
              fault_p1_nxt    = 1'b1;
              fault_pc_p1_nxt = pc_p0;
              vld_p1_nxt      = 1'b0;
            end else begin
              instr_p1_nxt = bus.imem_data;
              pc_p1_nxt    = pc_p0;
              vld_p1_nxt   = 1'b1;
              pc_p0_nxt    = pc_p0 + 32'd4;
            end
          end
        end
        FAULT: begin
          if (bus.out_ready) vld_p1_nxt = 1'b0;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // p0 -> p1 boundary: PC register feeds the registered IF/ID slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc_p0       <= RESET_PC;
      vld_p1      <= 1'b0;
      instr_p1    <= 32'd0;
      pc_p1       <= 32'd0;
      fault_p1    <= 1'b0;
      fault_pc_p1 <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc_p0       <= pc_p0_nxt;
      vld_p1      <= vld_p1_nxt;
      instr_p1    <= instr_p1_nxt;
      pc_p1       <= pc_p1_nxt;
      fault_p1    <= fault_p1_nxt;
      fault_pc_p1 <= fault_pc_p1_nxt;
    end
  end

  assign bus.imem_addr = pc_p0;
  assign bus.out_valid = vld_p1;
  assign bus.out_instr = instr_p1;
  assign bus.out_pc    = pc_p1;
  assign bus.fault     = fault_p1;
  assign bus.fault_pc  = fault_pc_p1;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: hand sequences for streaming/stall/flush/async reset, a vector
// table for fault and range cases, and a scoreboard of instructions accepted by decode.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_if bus ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(1024)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr);

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        push;
    logic [31:0] push_pc;
    logic        e_v;
    logic [31:0] e_pc;
    logic        e_f;
    logic [31:0] e_fpc;
    logic [31:0] e_addr;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                     input logic push, input logic [31:0] push_pc,
                     input logic e_v, input logic [31:0] e_pc, input logic e_f,
                     input logic [31:0] e_fpc, input logic [31:0] e_addr);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.push = push; v.push_pc = push_pc;
    v.e_v = e_v; v.e_pc = e_pc; v.e_f = e_f; v.e_fpc = e_fpc; v.e_addr = e_addr;
    tbl.push_back(v);
  endtask

  task automatic chk_slot(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({name, "_pc"}, bus.out_pc, pc);
    chk({name, "_instr"}, bus.out_instr, mem_word(pc));
  endtask

  // Decode side: an accepted slot must be the next expected instruction.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got pc %h expected no accept", bus.out_pc);
      end else begin
        logic [31:0] epc;
        epc = sb_q.pop_front();
        if (bus.out_pc !== epc || bus.out_instr !== mem_word(epc)) begin
          errors++;
          $display("FAIL sb_accept: got pc %h instr %h expected pc %h instr %h",
                   bus.out_pc, bus.out_instr, epc, mem_word(epc));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_pc", bus.out_pc, 32'h0);
    chk("rst_instr", bus.out_instr, 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'd0);
    chk("rst_fault_pc", bus.fault_pc, 32'h0);

    // Streaming from reset
    rst = 1'b0;
    sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
    step(); chk_slot("s0", 32'h0); chk("s0_addr", bus.imem_addr, 32'h4);
    step(); chk_slot("s1", 32'h4);
    step(); chk_slot("s2", 32'h8);
    step(); chk_slot("s3", 32'hC);

    // Redirect with a pending slot flushes it
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_addr", bus.imem_addr, 32'h40);
    bus.redirect_valid = 1'b0;
    sb_q.push_back(32'h40);
    step(); chk_slot("r0", 32'h40);
    step(); chk_slot("r1", 32'h44);

    // Stall holds slot and fetch address
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_slot("stall", 32'h44);
      chk("stall_addr", bus.imem_addr, 32'h48);
    end
    bus.out_ready = 1'b1;
    sb_q.push_back(32'h44);
    step(); chk_slot("unstall", 32'h48); chk("unstall_addr", bus.imem_addr, 32'h4C);

    // rv, rpc, rdy, push, push_pc, e_v, e_pc, e_f, e_fpc, e_addr
    add(1, 32'h42,       1, 0, 0,       0, 0,      0, 32'h0,       32'h42);
    add(0, 0,            1, 0, 0,       0, 0,      1, 32'h42,      32'h42);
    add(0, 0,            1, 0, 0,       0, 0,      1, 32'h42,      32'h42);
    add(0, 0,            0, 0, 0,       0, 0,      1, 32'h42,      32'h42);
    add(1, 32'h10,       1, 0, 0,       0, 0,      0, 32'h42,      32'h10);
    add(0, 0,            1, 0, 0,       1, 32'h10, 0, 32'h42,      32'h14);
    add(1, 32'h3F8,      0, 0, 0,       0, 0,      0, 32'h42,      32'h3F8);
    add(0, 0,            1, 0, 0,       1, 32'h3F8,0, 32'h42,      32'h3FC);
    add(0, 0,            1, 1, 32'h3F8, 1, 32'h3FC,0, 32'h42,      32'h400);
    add(0, 0,            0, 0, 0,       1, 32'h3FC,0, 32'h42,      32'h400);
    add(0, 0,            1, 1, 32'h3FC, 0, 0,      1, 32'h400,     32'h400);
    add(1, 32'hFFFF_FFFC,1, 0, 0,       0, 0,      0, 32'h400,     32'hFFFF_FFFC);
    add(0, 0,            1, 0, 0,       0, 0,      1, 32'hFFFF_FFFC,32'hFFFF_FFFC);
    add(1, 32'h3FC,      1, 0, 0,       0, 0,      0, 32'hFFFF_FFFC,32'h3FC);
    add(0, 0,            1, 0, 0,       1, 32'h3FC,0, 32'hFFFF_FFFC,32'h400);
    add(1, 32'h0,        1, 0, 0,       0, 0,      0, 32'hFFFF_FFFC,32'h0);
    add(0, 0,            1, 0, 0,       1, 32'h0,  0, 32'hFFFF_FFFC,32'h4);
    add(0, 0,            0, 0, 0,       1, 32'h0,  0, 32'hFFFF_FFFC,32'h4);

    for (int i = 0; i < tbl.size(); i++) begin
      bus.redirect_valid = tbl[i].rv;
      bus.redirect_pc    = tbl[i].rpc;
      bus.out_ready      = tbl[i].rdy;
      if (tbl[i].push) sb_q.push_back(tbl[i].push_pc);
      step();
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_v));
      chk($sformatf("v%0d_fault", i), 32'(bus.fault), 32'(tbl[i].e_f));
      chk($sformatf("v%0d_fault_pc", i), bus.fault_pc, tbl[i].e_fpc);
      chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].e_addr);
      if (tbl[i].e_v) begin
        chk($sformatf("v%0d_pc", i), bus.out_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_instr", i), bus.out_instr, mem_word(tbl[i].e_pc));
      end
    end

    // Async reset in the middle of a stall
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_addr", bus.imem_addr, 32'h0);
    chk("arst_instr", bus.out_instr, 32'h0);
    chk("arst_fault_pc", bus.fault_pc, 32'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    sb_q.push_back(32'h0); sb_q.push_back(32'h4);
    step(); chk_slot("rs0", 32'h0);
    step(); chk_slot("rs1", 32'h4);
    step(); chk_slot("rs2", 32'h8);
    bus.out_ready = 1'b0;
    step();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
